// File: rtl/tft_timing_gen.sv
// Parametrised TFT/RGB-panel timing generator: registered syncs/DE, strobes,
// a lookahead fetch-coordinate stream and run/stop control that ends on frame boundaries.
module tft_timing_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 50,
  parameter int H_SYNC    = 4,
  parameter int H_BP      = 26,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 20,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 1,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LEAD      = 11,
  parameter int FRAME_DIV = 60,
  parameter int COORD_W   = 10
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_run,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic               out_line_start,
  output logic               out_frame_start,
  output logic               out_frame_tick,
  output logic               out_fetch_valid,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_clk
);

  localparam int H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int H_DE_START = H_SYNC + H_BP;
  localparam int H_DE_END   = H_DE_START + H_ACTIVE;
  localparam int V_DE_START = V_SYNC + V_BP;
  localparam int V_DE_END   = V_DE_START + V_ACTIVE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] LEAD_H   = HW'(LEAD);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;
  logic [HW-1:0] lh_reg, lh_next;
  logic [VW-1:0] lv_reg, lv_next;
  logic [DW-1:0] div_reg, div_next;
  logic          active_next;
  logic          frame_start_next;
  logic          lead_next_frame;
  logic          fetch_valid_next;

  function automatic logic h_in_de(input logic [HW-1:0] h);
    return (int'(h) >= H_DE_START) && (int'(h) < H_DE_END);
  endfunction

  function automatic logic v_in_de(input logic [VW-1:0] v);
    return (int'(v) >= V_DE_START) && (int'(v) < V_DE_END);
  endfunction

  assign out_clk = in_clk;

  always_comb begin
    state_next  = state_reg;
    h_next      = '0;
    v_next      = '0;
    lh_next     = '0;
    lv_next     = '0;
    active_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_run) begin
          state_next  = RUN;
          lh_next     = LEAD_H;
          active_next = 1'b1;
        end
      end
      default: begin
        // A frame only ends after its last position has been shown.
        if (h_reg == H_LAST && v_reg == V_LAST && !in_run) begin
          state_next = IDLE;
        end else begin
          state_next  = in_run ? RUN : STOPPING;
          active_next = 1'b1;
          if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + VW'(1);
          end else begin
            h_next = h_reg + HW'(1);
            v_next = v_reg;
          end
          if (lh_reg == H_LAST) begin
            lh_next = '0;
            lv_next = (lv_reg == V_LAST) ? '0 : lv_reg + VW'(1);
          end else begin
            lh_next = lh_reg + HW'(1);
            lv_next = lv_reg;
          end
        end
      end
    endcase
  end

  // The lead pair is behind the main pair in linear order only once it has wrapped into the next frame.
  assign lead_next_frame  = (lv_next < v_next) || ((lv_next == v_next) && (lh_next < h_next));
  assign fetch_valid_next = active_next && h_in_de(lh_next) && v_in_de(lv_next)
                            && !((state_next == STOPPING) && lead_next_frame);
  assign frame_start_next = active_next && (h_next == '0) && (v_next == '0);

  always_comb begin
    div_next = div_reg;
    if (frame_start_next) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg       <= IDLE;
      h_reg           <= '0;
      v_reg           <= '0;
      lh_reg          <= '0;
      lv_reg          <= '0;
      div_reg         <= '0;
      out_hsync       <= ~HSYNC_POL;
      out_vsync       <= ~VSYNC_POL;
      out_de          <= 1'b0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_tick  <= 1'b0;
      out_fetch_valid <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
    end else begin
      state_reg       <= state_next;
      h_reg           <= h_next;
      v_reg           <= v_next;
      lh_reg          <= lh_next;
      lv_reg          <= lv_next;
      div_reg         <= div_next;
      out_hsync       <= (active_next && int'(h_next) < H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      out_vsync       <= (active_next && int'(v_next) < V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      out_de          <= active_next && h_in_de(h_next) && v_in_de(v_next);
      out_line_start  <= active_next && (h_next == '0);
      out_frame_start <= frame_start_next;
      out_frame_tick  <= frame_start_next && (div_reg == '0);
      out_fetch_valid <= fetch_valid_next;
      out_x           <= fetch_valid_next ? COORD_W'(int'(lh_next) - H_DE_START) : '0;
      out_y           <= fetch_valid_next ? COORD_W'(int'(lv_next) - V_DE_START) : '0;
    end
  end

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen on a small panel: directed run/stop/reset scenarios plus
// randomized run/reset traffic, all compared against a linear-position reference model.
module tb_tft_timing_gen;

  localparam int HA = 8, HF = 2, HS = 1, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TOT = HT * VT;
  localparam int LEAD = 3;
  localparam int FD = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;

  logic hs0, vs0, de0, ls0, fs0, ft0, fv0, oclk0;
  logic [CW-1:0] x0, y0;
  logic hs1, vs1, de1, ls1, fs1, ft1, fv1, oclk1;
  logic [CW-1:0] x1, y1;

  always #5 clk = ~clk;

  tft_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .LEAD(LEAD), .FRAME_DIV(FD), .COORD_W(CW)
  ) dut0 (
    .in_clk(clk), .in_rst(rst), .in_run(run),
    .out_hsync(hs0), .out_vsync(vs0), .out_de(de0),
    .out_line_start(ls0), .out_frame_start(fs0), .out_frame_tick(ft0),
    .out_fetch_valid(fv0), .out_x(x0), .out_y(y0), .out_clk(oclk0)
  );

  tft_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .LEAD(LEAD), .FRAME_DIV(FD), .COORD_W(CW)
  ) dut1 (
    .in_clk(clk), .in_rst(rst), .in_run(run),
    .out_hsync(hs1), .out_vsync(vs1), .out_de(de1),
    .out_line_start(ls1), .out_frame_start(fs1), .out_frame_tick(ft1),
    .out_fetch_valid(fv1), .out_x(x1), .out_y(y1), .out_clk(oclk1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: frame position as a single linear index 0..TOT-1.
  bit m_active = 0;
  bit m_stop = 0;
  int m_p = 0;
  int m_frames = 0;
  bit e_hs, e_vs, e_de, e_ls, e_fs, e_ft, e_fv;
  int e_x, e_y;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit de_at(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction

  task automatic model_edge(input bit r_run, input bit r_rst);
    int q;
    if (r_rst) begin
      m_active = 0; m_p = 0; m_stop = 0; m_frames = 0;
    end else if (!m_active) begin
      if (r_run) begin
        m_active = 1; m_p = 0; m_stop = 0;
      end
    end else if (m_p == TOT - 1 && !r_run) begin
      m_active = 0; m_p = 0; m_stop = 0;
    end else begin
      m_p = (m_p + 1) % TOT;
      m_stop = !r_run;
    end
    q = (m_p + LEAD) % TOT;
    e_hs = m_active && (m_p % HT) < HS;
    e_vs = m_active && (m_p / HT) < VS;
    e_de = m_active && de_at(m_p);
    e_ls = m_active && (m_p % HT) == 0;
    e_fs = m_active && m_p == 0;
    e_ft = e_fs && (m_frames % FD == 0);
    if (e_fs) m_frames++;
    e_fv = m_active && de_at(q) && !(m_stop && q < m_p);
    e_x = e_fv ? (q % HT) - (HS + HB) : 0;
    e_y = e_fv ? (q / HT) - (VS + VB) : 0;
  endtask

  task automatic step(input bit s_run, input bit s_rst);
    run = s_run;
    rst = s_rst;
    @(posedge clk);
    model_edge(s_run, s_rst);
    #1;
    cyc++;
    check_eq("hsync0", 32'(hs0), 32'(!e_hs));
    check_eq("vsync0", 32'(vs0), 32'(!e_vs));
    check_eq("de0", 32'(de0), 32'(e_de));
    check_eq("line_start", 32'(ls0), 32'(e_ls));
    check_eq("frame_start", 32'(fs0), 32'(e_fs));
    check_eq("frame_tick", 32'(ft0), 32'(e_ft));
    check_eq("fetch_valid", 32'(fv0), 32'(e_fv));
    check_eq("x", 32'(x0), 32'(e_x));
    check_eq("y", 32'(y0), 32'(e_y));
    check_eq("hsync1", 32'(hs1), 32'(e_hs));
    check_eq("vsync1", 32'(vs1), 32'(e_vs));
    check_eq("de1", 32'(de1), 32'(e_de));
    check_eq("fetch_valid1", 32'(fv1), 32'(e_fv));
    check_eq("out_clk", 32'(oclk0), 32'(1));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  bit fv_hist[0:299];
  int de_cnt;
  int tick_cnt;
  bit run_cur;
  bit rst_cur;

  initial begin
    do_reset();

    // Continuous run over three frames plus a little.
    de_cnt = 0;
    tick_cnt = 0;
    for (int k = 0; k < 261; k++) begin
      step(1'b1, 1'b0);
      fv_hist[k] = fv0;
      if (k >= LEAD) check_eq("lead_vs_de", 32'(fv_hist[k-LEAD]), 32'(de0));
      if (de0) de_cnt++;
      if (ft0) tick_cnt++;
      if (k == 26) check_eq("first_de_k26", 32'(de0), 32'(1));
      if (k == 30) check_eq("x_at_k30", 32'(x0), 32'(7));
      if (k == 84 || k == 168 || k == 252) check_eq("fs_period", 32'(fs0), 32'(1));
      if (k == 83 || k == 167 || k == 251) begin
        check_eq("de_per_frame", 32'(de_cnt), 32'(32));
        de_cnt = 0;
      end
    end
    check_eq("tick_count", 32'(tick_cnt), 32'(2));
    for (int k = 0; k < 90; k++) step(1'b0, 1'b0);

    // Drop and re-raise run inside a frame: no discontinuity.
    do_reset();
    for (int k = 0; k < 90; k++) begin
      step(!(k >= 40 && k < 60), 1'b0);
      if (k == 84) check_eq("fs_after_resume", 32'(fs0), 32'(1));
    end
    for (int k = 0; k < 90; k++) step(1'b0, 1'b0);

    // Drop run and hold low: frame completes, then idle.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      step(k < 40, 1'b0);
      if (k == 84) begin
        check_eq("stop_idle_fs", 32'(fs0), 32'(0));
        check_eq("stop_idle_hs", 32'(hs0), 32'(1));
      end
    end
    step(1'b1, 1'b0);
    check_eq("restart_fs", 32'(fs0), 32'(1));
    for (int k = 0; k < 90; k++) step(1'b0, 1'b0);

    // Reset mid-frame with run held high.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      step(1'b1, k == 50);
      if (k == 50) check_eq("rst_mid_ls", 32'(ls0), 32'(0));
      if (k == 51) check_eq("rst_restart_fs", 32'(fs0), 32'(1));
    end

    // Randomized run toggling and occasional resets.
    run_cur = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) run_cur = ~run_cur;
      rst_cur = ($urandom_range(0, 299) == 0);
      step(run_cur, rst_cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
